img_line_buffer: RTL
====================

IMG_LINE_BUFFER -- requirements
Module: img_line_buffer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of parallel pixel channels, range 1..8.
REQ-002 SHALL have parameter PIX_W, default 16: pixel width in bits, a multiple of 8, range 8..32.
REQ-003 SHALL have parameter DEPTH, default 16: pixels captured per channel per line, range 2..4096.
REQ-004 SHALL have parameter SYNC_WORD, default 16'hAAAA (PIX_W bits): channel-0 line marker.
REQ-005 SHALL have parameter MSB_FIRST, default 0: 0 sends pixel bytes LSB first, 1 sends them MSB first.
REQ-006 clk40M  in  1  sole clock; every register updates on its rising edge.
REQ-007 nRst  in  1  reset, synchronous and active-low.
REQ-008 arm  in  1  one-cycle request to start hunting for a line.
REQ-009 abort  in  1  forces return to IDLE.
REQ-010 pix_valid  in  1  pix_data is valid this cycle.
REQ-011 pix_data  in  NUM_CH*PIX_W  channel k occupies bits [k*PIX_W +: PIX_W].
REQ-012 tx_data  out  8  byte offered to the UART transmitter.
REQ-013 tx_valid  out  1  tx_data is valid.
REQ-014 tx_ready  in  1  transmitter accepts the byte; a transfer occurs when tx_valid and tx_ready are both 1.
REQ-015 busy  out  1  state is not IDLE.
REQ-016 done  out  1  one-cycle pulse when a line has been fully drained.

Function
REQ-017 SHALL implement the states IDLE, HUNT, CAPTURE and DRAIN.
REQ-018 IDLE: arm=1 SHALL move to HUNT; pix_valid SHALL be ignored.
REQ-019 HUNT: pix_valid=1 with channel 0 equal to SYNC_WORD SHALL move to CAPTURE; that marker beat SHALL NOT be stored.
REQ-020 CAPTURE: each pix_valid beat SHALL write all channels to line address wr_ptr and increment wr_ptr.
REQ-021 CAPTURE: the beat with wr_ptr=DEPTH-1 SHALL be the last write, after which the state SHALL move to DRAIN.
REQ-022 DRAIN byte order: pixel index 0..DEPTH-1 (outer), channel 0..NUM_CH-1 (middle), PIX_W/8 bytes per pixel (inner), with the inner order set by MSB_FIRST.
REQ-023 DRAIN SHALL emit exactly DEPTH*NUM_CH*PIX_W/8 bytes; with default parameters this is 128.
REQ-024 The first tx_valid SHALL assert 2 cycles after the last capture write.
REQ-025 After a transfer in cycle t, tx_valid SHALL be 0 in cycle t+1 and the next byte SHALL be valid in cycle t+2.
REQ-026 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable indefinitely.
REQ-027 The cycle after the final transfer, done SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-028 arm SHALL be ignored in HUNT, CAPTURE and DRAIN.
REQ-029 pix_valid SHALL be ignored in DRAIN; a new line requires a new arm.
REQ-030 abort SHALL return the block to IDLE on the next edge from any state and SHALL clear tx_valid and both pointers.
REQ-031 If abort and arm are high in the same cycle, abort SHALL win.
REQ-032 wr_ptr and the read byte counter SHALL NOT wrap; both terminate at their final counts as stated above.

Reset
REQ-033 With nRst=0 at a clock edge: state=IDLE, tx_valid=0, tx_data=8'h00, done=0, busy=0, all pointers 0.
REQ-034 Reset mid-line SHALL discard the captured data; the RAM contents need not be cleared.

Structure
REQ-035 Package img_buf_pkg SHALL hold the state enum, the default SYNC_WORD, and an address-width function clog2(DEPTH).
REQ-036 The line storage SHALL be a sub-module img_line_ram: simple dual-port, NUM_CH*PIX_W wide, DEPTH deep, one write port, and a registered read with 1-cycle latency.

Verification
REQ-037 Defaults, arm, channel-0 beats 0000, FFFF, FFFF, AAAA, then 0000..000F -> 128 bytes 00,00,00,00,00,00,00,00,01,00,01,00,... then done.
REQ-038 MSB_FIRST=1, same stimulus -> bytes 00,00,... with pixel 1 sent as 00,01 on each channel; total count 128.
REQ-039 tx_ready held low for 50 cycles mid-drain -> tx_data stable throughout; no byte lost or duplicated.
REQ-040 Beats without AAAA after arm -> no tx_valid and busy=1; abort -> IDLE next cycle with busy=0.
REQ-041 nRst pulsed during CAPTURE with wr_ptr=7 -> all outputs at reset values; a new arm plus a full line drains correctly.
REQ-042 NUM_CH=1, PIX_W=8, DEPTH=2, line 5A, C3 -> bytes 5A, C3, then done.

Source files
------------

// File: rtl/img_buf_pkg.sv
// Shared types and helpers for the image line buffer.
// Holds the controller state encoding, the default line marker and an address-width helper.
package img_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_CAPTURE,
    ST_DRAIN
  } state_e;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hAAAA;

  // Never returns less than 1, so single-entry ranges still get a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/img_line_ram.sv
// Simple dual-port line store: one write port, one read port with a 1-cycle registered read.
// Contents are not reset; the controller never reads an address before writing it for the current line.
module img_line_ram #(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/img_line_buffer.sv
// Captures one line of NUM_CH parallel pixels after a channel-0 marker, then serialises it
// byte by byte to a UART transmitter with a valid/ready handshake (one idle cycle between bytes).
module img_line_buffer
  import img_buf_pkg::*;
#(
  parameter int               NUM_CH    = 4,
  parameter int               PIX_W     = 16,
  parameter int               DEPTH     = 16,
  parameter logic [PIX_W-1:0] SYNC_WORD = PIX_W'(SYNC_WORD_DEFAULT),
  parameter bit               MSB_FIRST = 1'b0
) (
  input  logic                    clk40M,
  input  logic                    nRst,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    pix_valid,
  input  logic [NUM_CH*PIX_W-1:0] pix_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = NUM_CH * PIX_W;
  localparam int NB = PIX_W / 8;
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(NUM_CH);
  localparam int BW = clog2(NB);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_pix_q, rd_pix_d;
  logic [CW-1:0] rd_ch_q, rd_ch_d;
  logic [BW-1:0] rd_byte_q, rd_byte_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          done_q, done_d;

  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic [BW-1:0] byte_sel;
  logic [7:0]    cur_byte;

  // Read address follows the next pixel index so the RAM output is ready for the load cycle.
  img_line_ram #(
    .W     (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk40M),
    .we_i    (ram_we && nRst),
    .waddr_i (wr_ptr_q),
    .wdata_i (pix_data),
    .raddr_i (rd_pix_d),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    byte_sel = MSB_FIRST ? (LAST_BYTE - rd_byte_q) : rd_byte_q;
    cur_byte = 8'(ram_rdata >> (32'(rd_ch_q) * PIX_W + 32'(byte_sel) * 8));
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_pix_d   = rd_pix_q;
    rd_ch_d    = rd_ch_q;
    rd_byte_d  = rd_byte_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    ram_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (pix_valid && (pix_data[PIX_W-1:0] == SYNC_WORD)) begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (pix_valid) begin
          ram_we = 1'b1;
          if (wr_ptr_q == LAST_ADDR) state_d = ST_DRAIN;
          else                       wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = cur_byte;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (rd_byte_q != LAST_BYTE) begin
            rd_byte_d = rd_byte_q + BW'(1);
          end else begin
            rd_byte_d = '0;
            if (rd_ch_q != LAST_CH) begin
              rd_ch_d = rd_ch_q + CW'(1);
            end else begin
              rd_ch_d = '0;
              if (rd_pix_q != LAST_ADDR) begin
                rd_pix_d = rd_pix_q + AW'(1);
              end else begin
                state_d  = ST_IDLE;
                done_d   = 1'b1;
                rd_pix_d = '0;
                wr_ptr_d = '0;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_pix_d   = '0;
      rd_ch_d    = '0;
      rd_byte_d  = '0;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
      ram_we     = 1'b0;
    end
  end

  always_ff @(posedge clk40M) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_pix_q   <= '0;
      rd_ch_q    <= '0;
      rd_byte_q  <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_pix_q   <= rd_pix_d;
      rd_ch_q    <= rd_ch_d;
      rd_byte_q  <= rd_byte_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
